// File: rtl/svo_vtiming_ctrl_pkg.sv
// Shared raster timing definitions for the SVO video path: 640x480@60 defaults,
// controller FSM state type, 11-bit coordinate type and a wrapping increment helper.
package svo_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_LOCK_DLY = 1024;

  localparam int COORD_W = 11;
  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } vt_state_e;

  function automatic coord_t wrap_inc(input coord_t v, input coord_t last);
    return (v == last) ? '0 : v + coord_t'(1);
  endfunction

endpackage

// File: rtl/svo_vtiming_ctrl_if.sv
// Timing controller bundle: PLL lock in, TMDS-side sync/blank/position out,
// and the line-fetch request/ack handshake toward the line buffer.
interface svo_vtiming_ctrl_if;
  import svo_timing_pkg::*;

  logic   locked;
  logic   ser_reset;
  logic   hsync_n;
  logic   vsync_n;
  logic   blank;
  logic   sof;
  coord_t x;
  coord_t y;
  logic   line_req;
  coord_t line_num;
  logic   line_ack;
  logic   underrun;

  modport master (
    input  locked, line_ack,
    output ser_reset, hsync_n, vsync_n, blank, sof, x, y, line_req, line_num, underrun
  );

  modport slave (
    output locked, line_ack,
    input  ser_reset, hsync_n, vsync_n, blank, sof, x, y, line_req, line_num, underrun
  );

endinterface

// File: rtl/svo_vtiming_ctrl_lock_settle.sv
// Lock debounce: counts consecutive locked cycles since clr_i dropped; settled_o on the last one.
// Combinational settled_o from a registered count; no backpressure.
module svo_lock_settle #(
  parameter int LOCK_DLY = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic locked_i,
  output logic settled_o
);

  localparam int CW = $clog2(LOCK_DLY) + 1;
  localparam logic [CW-1:0] LAST = CW'(LOCK_DLY - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (locked_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign settled_o = locked_i && (cnt_q == LAST);

endmodule

// File: rtl/svo_vtiming_ctrl.sv
// Video timing controller: lock bring-up FSM, raster counters, sync/blank and line-fetch scheduling.
// All outputs registered and aligned to the same cycle's raster position; line_req holds until line_ack or line end.
module svo_vtiming_ctrl
  import svo_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int LOCK_DLY = DEF_LOCK_DLY
) (
  input  logic               clk_pixel,
  input  logic               resetn,
  svo_vtiming_ctrl_if.master vt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
  localparam coord_t HA_C   = coord_t'(H_ACTIVE);
  localparam coord_t VA_C   = coord_t'(V_ACTIVE);
  // Sync window bounds kept one bit wider so an end of exactly 2048 still compares correctly.
  localparam logic [COORD_W:0] HS_BEG = (COORD_W+1)'(H_ACTIVE + H_FP);
  localparam logic [COORD_W:0] HS_END = (COORD_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W:0] VS_BEG = (COORD_W+1)'(V_ACTIVE + V_FP);
  localparam logic [COORD_W:0] VS_END = (COORD_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  vt_state_e state_q, state_d;
  coord_t    h_q, h_d, v_q, v_d;
  logic      settled;
  logic      run_d;

  logic      ser_reset_q, ser_reset_d;
  logic      hsync_n_q, hsync_n_d;
  logic      vsync_n_q, vsync_n_d;
  logic      blank_q, blank_d;
  logic      sof_q, sof_d;
  logic      req_q, req_d;
  coord_t    num_q, num_d;
  logic      urun_q, urun_d;
  coord_t    nxt_line;

  svo_lock_settle #(
    .LOCK_DLY (LOCK_DLY)
  ) u_lock_settle (
    .clk_i     (clk_pixel),
    .rst_ni    (resetn),
    .clr_i     (state_q != ST_SETTLE),
    .locked_i  (vt.locked),
    .settled_o (settled)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (vt.locked) state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (!vt.locked)   state_d = ST_IDLE;
        else if (settled) state_d = ST_RUN;
      end
      ST_RUN:    if (!vt.locked) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign run_d = (state_d == ST_RUN);

  // Counters restart at (0,0) on the first RUN cycle and sit at zero outside RUN.
  always_comb begin
    h_d = '0;
    v_d = '0;
    if (run_d && (state_q == ST_RUN)) begin
      h_d = wrap_inc(h_q, H_LAST);
      v_d = (h_q == H_LAST) ? wrap_inc(v_q, V_LAST) : v_q;
    end
  end

  // Output registers load from next-state position so they line up with the counters.
  always_comb begin
    ser_reset_d = !run_d;
    hsync_n_d   = !(run_d && ({1'b0, h_d} >= HS_BEG) && ({1'b0, h_d} < HS_END));
    vsync_n_d   = !(run_d && ({1'b0, v_d} >= VS_BEG) && ({1'b0, v_d} < VS_END));
    blank_d     = !run_d || (h_d >= HA_C) || (v_d >= VA_C);
    sof_d       = run_d && (h_d == '0) && (v_d == '0);
  end

  assign nxt_line = wrap_inc(v_d, V_LAST);

  // Pending request resolves on ack or at the line's last pixel; a new one opens when blank rises.
  always_comb begin
    req_d  = req_q;
    num_d  = num_q;
    urun_d = urun_q;
    if (req_q) begin
      if (vt.line_ack) begin
        req_d = 1'b0;
      end else if (h_q == H_LAST) begin
        req_d  = 1'b0;
        urun_d = 1'b1;
      end
    end
    if (!run_d) begin
      req_d = 1'b0;
    end else if ((h_d == HA_C) && (nxt_line < VA_C)) begin
      req_d = 1'b1;
      num_d = nxt_line;
    end
  end

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      h_q         <= '0;
      v_q         <= '0;
      ser_reset_q <= 1'b1;
      hsync_n_q   <= 1'b1;
      vsync_n_q   <= 1'b1;
      blank_q     <= 1'b1;
      sof_q       <= 1'b0;
      req_q       <= 1'b0;
      num_q       <= '0;
      urun_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      ser_reset_q <= ser_reset_d;
      hsync_n_q   <= hsync_n_d;
      vsync_n_q   <= vsync_n_d;
      blank_q     <= blank_d;
      sof_q       <= sof_d;
      req_q       <= req_d;
      num_q       <= num_d;
      urun_q      <= urun_d;
    end
  end

  assign vt.ser_reset = ser_reset_q;
  assign vt.hsync_n   = hsync_n_q;
  assign vt.vsync_n   = vsync_n_q;
  assign vt.blank     = blank_q;
  assign vt.sof       = sof_q;
  assign vt.x         = h_q;
  assign vt.y         = v_q;
  assign vt.line_req  = req_q;
  assign vt.line_num  = num_q;
  assign vt.underrun  = urun_q;

endmodule

// File: tb/tb_svo_vtiming_ctrl.sv
// Bench for svo_vtiming_ctrl on a reduced raster (25x15) with a frame-position reference model.
// Directed vector table, fetch deadline corners, lock loss, async reset and random lock/ack stimulus.
module tb_svo_vtiming_ctrl;
  import svo_timing_pkg::*;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int LD = 12;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic clk_pixel = 1'b0;
  logic resetn    = 1'b1;

  svo_vtiming_ctrl_if vif ();

  svo_vtiming_ctrl #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .LOCK_DLY (LD)
  ) dut (
    .clk_pixel (clk_pixel),
    .resetn    (resetn),
    .vt        (vif)
  );

  always #5 clk_pixel = ~clk_pixel;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 idle, 1 settling, 2 running; m_t is the pixel index within the frame.
  int     m_mode, m_scnt, m_t, m_num;
  logic   m_req, m_urun;

  logic   s_ser, s_hs, s_vs, s_bl, s_sof, s_req, s_urun;
  coord_t s_x, s_y, s_num;

  typedef struct {
    int   h;
    int   v;
    logic hs;
    logic vs;
    logic bl;
    logic sof;
    logic req;
    int   num;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic sample();
    s_ser  = vif.ser_reset;
    s_hs   = vif.hsync_n;
    s_vs   = vif.vsync_n;
    s_bl   = vif.blank;
    s_sof  = vif.sof;
    s_req  = vif.line_req;
    s_urun = vif.underrun;
    s_x    = vif.x;
    s_y    = vif.y;
    s_num  = vif.line_num;
  endtask

  task automatic model_reset();
    m_mode = 0; m_scnt = 0; m_t = 0; m_num = 0;
    m_req  = 1'b0; m_urun = 1'b0;
  endtask

  task automatic model_step(input logic lk, input logic ak, input int cx);
    int nx, ny, nl;
    if (m_req) begin
      if (ak) m_req = 1'b0;
      else if (cx == HT - 1) begin
        m_req  = 1'b0;
        m_urun = 1'b1;
      end
    end
    case (m_mode)
      0: if (lk) begin m_mode = 1; m_scnt = 0; end
      1: begin
        if (!lk) m_mode = 0;
        else if (m_scnt == LD - 1) begin m_mode = 2; m_t = 0; end
        else m_scnt++;
      end
      default: begin
        if (!lk) m_mode = 0;
        else m_t = (m_t + 1) % (HT * VT);
      end
    endcase
    if (m_mode == 2) begin
      nx = m_t % HT;
      ny = m_t / HT;
      if (nx == HA) begin
        nl = (ny == VT - 1) ? 0 : ny + 1;
        if (nl < VA) begin
          m_req = 1'b1;
          m_num = nl;
        end
      end
    end else begin
      m_req = 1'b0;
    end
  endtask

  // One clock: drive inputs, sample mid-cycle, compare against the model, advance the model.
  task automatic cycle(input logic lk, input logic ak);
    int cx, cy;
    logic run, e_hs, e_vs, e_bl, e_sof;
    logic [28:0] a, e;
    vif.locked   = lk;
    vif.line_ack = ak;
    @(negedge clk_pixel);
    sample();
    run   = (m_mode == 2);
    cx    = run ? m_t % HT : 0;
    cy    = run ? m_t / HT : 0;
    e_hs  = !(run && cx >= HA + HF && cx < HA + HF + HS);
    e_vs  = !(run && cy >= VA + VF && cy < VA + VF + VS);
    e_bl  = !run || cx >= HA || cy >= VA;
    e_sof = run && m_t == 0;
    a = {s_ser, s_hs, s_vs, s_bl, s_sof, s_req, s_urun, s_x, s_y};
    e = {!run, e_hs, e_vs, e_bl, e_sof, m_req, m_urun, coord_t'(cx), coord_t'(cy)};
    chk("model_outputs", 64'(a), 64'(e));
    if (m_req) chk("model_line_num", 64'(s_num), 64'(m_num));
    model_step(lk, ak, cx);
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic bringup();
    int n;
    n = 0;
    do begin
      cycle(1'b1, 1'b1);
      if (s_ser) n++;
    end while (s_ser && n < 4 * LD);
    chk("bringup_len", 64'(n), 64'(LD + 1));
    chk("first_sof", 64'({s_sof, s_ser, s_x, s_y}), 64'({1'b1, 1'b0, 22'd0}));
  endtask

  task automatic goto(input int h, input int v);
    int n;
    n = 0;
    while (!(m_mode == 2 && m_t == v * HT + h) && n < 2 * HT * VT) begin
      cycle(1'b1, 1'b1);
      n++;
    end
    chk("goto_reach", 64'(m_mode == 2 && m_t == v * HT + h), 64'd1);
  endtask

  localparam logic [39:0] RST_VALS = {7'b1111000, 33'd0};

  initial begin
    int cur, k, n_act, n_sof, n_hs, n_vs;

    tbl[0]  = '{1,  0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[1]  = '{15, 0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[2]  = '{16, 0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1};
    tbl[3]  = '{17, 0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[4]  = '{18, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[5]  = '{21, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[6]  = '{22, 0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[7]  = '{24, 0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[8]  = '{0,  1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[9]  = '{16, 6,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7};
    tbl[10] = '{16, 7,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[11] = '{5,  8,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[12] = '{0,  10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[13] = '{20, 11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[14] = '{0,  12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[15] = '{16, 14, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0};
    tbl[16] = '{0,  15, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0};

    vif.locked   = 1'b0;
    vif.line_ack = 1'b0;
    model_reset();
    #1 resetn = 1'b0;
    #6;
    sample();
    chk("reset_values", 64'({s_ser, s_hs, s_vs, s_bl, s_sof, s_req, s_urun, s_x, s_y, s_num}), 64'(RST_VALS));
    @(posedge clk_pixel);
    #1 resetn = 1'b1;

    bringup();

    // Walk the first frame with line_ack tied high, checking fixed raster points.
    cur = 1;
    for (int i = 0; i < 17; i++) begin
      k = tbl[i].v * HT + tbl[i].h;
      while (cur < k) begin
        cycle(1'b1, 1'b1);
        cur++;
      end
      cycle(1'b1, 1'b1);
      cur++;
      chk($sformatf("vec%0d", i), 64'({s_hs, s_vs, s_bl, s_sof, s_req, s_x, s_y}),
          64'({tbl[i].hs, tbl[i].vs, tbl[i].bl, tbl[i].sof, tbl[i].req,
               coord_t'(tbl[i].h), coord_t'(tbl[i].v % VT)}));
      if (tbl[i].req) chk($sformatf("vec%0d_num", i), 64'(s_num), 64'(tbl[i].num));
    end

    // Any full-frame window holds a fixed number of active, sync and sof cycles.
    n_act = 0; n_sof = 0; n_hs = 0; n_vs = 0;
    for (int i = 0; i < HT * VT; i++) begin
      cycle(1'b1, 1'b1);
      if (!s_bl) n_act++;
      if (s_sof) n_sof++;
      if (!s_hs) n_hs++;
      if (!s_vs) n_vs++;
    end
    chk("frame_active_cnt", 64'(n_act), 64'(HA * VA));
    chk("frame_sof_cnt",    64'(n_sof), 64'd1);
    chk("frame_hsync_cnt",  64'(n_hs),  64'(HS * VT));
    chk("frame_vsync_cnt",  64'(n_vs),  64'(VS * HT));

    // Ack on the deadline pixel is a success.
    goto(15, 2);
    for (int h = 15; h < HT - 1; h++) cycle(1'b1, 1'b0);
    chk("dl_req_before", 64'({s_req, s_num}), 64'({1'b1, 11'd3}));
    cycle(1'b1, 1'b1);
    chk("dl_req_at_last", 64'({s_req, s_x}), 64'({1'b1, coord_t'(HT - 1)}));
    cycle(1'b1, 1'b1);
    chk("dl_after", 64'({s_req, s_urun, s_x}), 64'({1'b0, 1'b0, 11'd0}));

    // Missed deadline: request held to the last pixel, then dropped with sticky underrun.
    goto(16, 3);
    for (int h = 16; h < HT; h++) cycle(1'b1, 1'b0);
    chk("ur_last_pixel", 64'({s_req, s_num, s_urun}), 64'({1'b1, 11'd4, 1'b0}));
    cycle(1'b1, 1'b1);
    chk("ur_next_line", 64'({s_req, s_urun, s_x, s_y}), 64'({1'b0, 1'b1, 11'd0, 11'd4}));
    for (int i = 0; i < 2 * HT; i++) cycle(1'b1, 1'b1);
    chk("ur_sticky", 64'(s_urun), 64'd1);

    // Lock loss mid-line: IDLE outputs next cycle, underrun retained, then re-lock.
    goto(10, 5);
    cycle(1'b0, 1'b1);
    chk("lock_drop_pos", 64'({s_ser, s_x, s_y}), 64'({1'b0, 11'd10, 11'd5}));
    cycle(1'b0, 1'b1);
    chk("lock_drop_idle", 64'({s_ser, s_hs, s_vs, s_bl, s_sof, s_req, s_urun, s_x, s_y}),
        64'({7'b1111001, 22'd0}));
    bringup();

    // Asynchronous reset in the middle of a line.
    goto(7, 2);
    cycle(1'b1, 1'b1);
    #2 resetn = 1'b0;
    #1;
    sample();
    chk("async_reset", 64'({s_ser, s_hs, s_vs, s_bl, s_sof, s_req, s_urun, s_x, s_y, s_num}), 64'(RST_VALS));
    model_reset();
    @(posedge clk_pixel);
    @(posedge clk_pixel);
    #1 resetn = 1'b1;
    bringup();

    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 299) != 0), 1'($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/svo_vtiming_ctrl.md
# svo_vtiming_ctrl

Video timing controller and line-fetch scheduler for the HDMI output path. It sequences link bring-up after PLL lock, generates the raster counters and the hsync_n/vsync_n/blank controls consumed by the TMDS encoders, and holds serializer reset until timing is stable. It also issues one line-fetch request per active line to the framebuffer/line-buffer side, with a deadline-based underrun check.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- LOCK_DLY, 1024, consecutive clk_pixel cycles of locked required before RUN

Ports:
- clk_pixel  in  1  pixel clock; the only clock
- resetn  in  1  asynchronous, active-low reset
- locked  in  1  PLL lock; already synchronised to clk_pixel
- ser_reset  out  1  serializer reset, active high
- hsync_n  out  1  horizontal sync, active low
- vsync_n  out  1  vertical sync, active low
- blank  out  1  high outside the active area (DE = !blank)
- sof  out  1  one-cycle pulse at pixel (0,0)
- x  out  11  current column
- y  out  11  current line
- line_req  out  1  fetch request for line line_num
- line_num  out  11  line being requested
- line_ack  in  1  fetch accepted
- underrun  out  1  sticky; set on missed fetch deadline

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Counters h_cnt, v_cnt are 11 bits; parameters are constrained so both totals ≤ 2048.
- FSM states: IDLE, SETTLE, RUN.
  - IDLE: locked=0 → stay. locked=1 → SETTLE, lock counter cleared.
  - SETTLE: counts cycles while locked=1; locked=0 → IDLE. Count reaches LOCK_DLY-1 → RUN with h_cnt=0, v_cnt=0.
  - RUN: locked=0 → IDLE next cycle.
- Outside RUN: ser_reset=1, hsync_n=1, vsync_n=1, blank=1, sof=0, x=y=0, line_req=0, counters held at 0. In RUN, ser_reset=0.
- Raster (RUN): h_cnt increments and wraps at H_TOTAL-1; v_cnt increments on h wrap and wraps at V_TOTAL-1.
  - hsync_n=0 for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync_n=0 for V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC; changes only at h_cnt=0.
  - blank = (h_cnt ≥ H_ACTIVE) | (v_cnt ≥ V_ACTIVE).
  - sof = (h_cnt=0 & v_cnt=0). x=h_cnt, y=v_cnt.
- Fetch scheduler (RUN):
  - At h_cnt=H_ACTIVE, compute next = (v_cnt=V_TOTAL-1) ? 0 : v_cnt+1. If next < V_ACTIVE, assert line_req with line_num=next.
  - line_req holds with stable line_num until a cycle with line_ack=1. It drops the cycle after that.
  - Deadline is h_cnt=H_TOTAL-1. An ack in that cycle counts as success. If there is no ack by the deadline, line_req drops and underrun sets.
  - line_ack while line_req=0 is ignored.
- underrun clears only on resetn. It is not cleared by loss of lock.
- resetn low mid-frame → all state and outputs go to the IDLE values immediately (asynchronous).

## Timing
- All outputs registered. Reset values: ser_reset=1, hsync_n=1, vsync_n=1, blank=1, sof=0, x=y=0, line_req=0, line_num=0, underrun=0.
- RUN entered at cycle N: outputs reflect position (0,0) at cycle N+1. sof=1 and ser_reset=0 on that same cycle.
- Output at any RUN cycle reflects the counter value of that cycle, with zero relative skew between sync, blank, x and y.
- line_req rises the cycle blank rises on a line whose successor is active.
- Lock loss in RUN: IDLE outputs appear on the next cycle. No frame completion.

## Structure
- Shared package svo_timing_pkg holds the 640x480@60 default constants, the FSM state enum and the 11-bit coordinate type, for reuse by other timing blocks.
- Sub-module svo_lock_settle (locked debounce counter → settled pulse/level) is split out. Counters and fetch logic stay in the top.

## Test plan
- Reset, locked=1 from cycle 0: ser_reset=1 for LOCK_DLY+1 cycles. Then sof=1 with x=0, y=0 and ser_reset=0.
- One full frame: hsync_n low for h_cnt 656..751 (96 cycles/line). vsync_n low for lines 490..491. blank low for exactly 640×480 cycles. Period 800×525 cycles.
- line_ack tied high: line_req pulses 1 cycle at h_cnt=640 on lines 0..478 (line_num=y+1) and on line 524 (line_num=0). No request on lines 479..523. underrun stays 0.
- line_ack never asserted on line 10: line_req (line_num=11) stays high through h_cnt=799, drops at h_cnt=0. underrun=1 and stays set.
- Ack exactly at h_cnt=799: no underrun, line_req drops next cycle.
- locked drops at x=300, y=200: next cycle IDLE outputs. Re-lock restarts SETTLE, then a frame starts at (0,0). underrun unchanged. Async resetn pulse mid-line gives immediate reset values.
